// File: rtl/rr_encoder_16_4.sv
// Sequential 16:4 round-robin encoder: latches request pulses into a sticky
// pending mask and streams their 4-bit indices out over a valid/ready handshake.
module rr_encoder_16_4 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] line,
    input  logic        ready,
    output logic [3:0]  id,
    output logic        valid,
    output logic [15:0] pending,
    output logic [4:0]  count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. Once valid rises, id is held stable until that transfer occurs.
    // ready has no effect while valid is low.

    logic [15:0] pending_q;
    logic [3:0]  ptr_q;
    logic [3:0]  id_q;
    logic        valid_q;

    logic        acc;
    logic        reload;
    logic [15:0] pend_after;
    logic [15:0] pending_next;
    logic [3:0]  ptr_next;

    logic        hit;
    logic [3:0]  hit_idx;
    logic [3:0]  idx;

    always_comb begin
        acc          = valid_q & ready;
        reload       = ~valid_q | acc;
        pend_after   = pending_q;
        if (acc) begin
            pend_after[id_q] = 1'b0;
        end
        // A new pulse on the bit being accepted re-arms it.
        pending_next = pend_after | line;
        ptr_next     = ptr_q;
        if (acc) begin
            ptr_next = id_q + 4'd1;
        end
        if (!ROUND_ROBIN) begin
            ptr_next = 4'd0;
        end
    end

    // Walk from the farthest offset down to ptr_next so the nearest set bit wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        idx     = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr_next + 4'(k);
            if (pend_after[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(pending_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 16'd0;
            ptr_q     <= 4'd0;
            id_q      <= 4'd0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_next;
            ptr_q     <= ptr_next;
            if (reload) begin
                valid_q <= hit;
                if (hit) begin
                    id_q <= hit_idx;
                end
            end
        end
    end

    assign id      = id_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_rr_encoder_16_4.sv
// Self-checking bench for rr_encoder_16_4: directed scenarios plus random traffic
// on a round-robin and a fixed-priority instance, checked against a per-cycle model.
module tb_rr_encoder_16_4;

    localparam int W = 26;

    logic        clk;
    logic        rst_n;
    logic [15:0] line;
    logic        ready;

    logic [3:0]  id0, id1;
    logic        valid0, valid1;
    logic [15:0] pending0, pending1;
    logic [4:0]  count0, count1;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // Model state: [0] round-robin instance, [1] fixed-priority instance.
    logic [15:0] m_pend[2];
    int          m_ptr[2];
    int          m_id[2];
    bit          m_valid[2];

    rr_encoder_16_4 #(.ROUND_ROBIN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .line(line), .ready(ready),
        .id(id0), .valid(valid0), .pending(pending0), .count(count0)
    );

    rr_encoder_16_4 #(.ROUND_ROBIN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .line(line), .ready(ready),
        .id(id1), .valid(valid1), .pending(pending1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next-cycle outputs derived from the rules: drop the accepted line, then
    // pick the nearest pending index going up from the pointer, wrapping at 16.
    task automatic model_step(input int u, input bit rr, input logic rst_l,
                              input logic [15:0] l, input logic rd);
        bit          acc;
        bit          found;
        int          pn;
        int          n;
        logic [15:0] pa;
        if (!rst_l) begin
            m_pend[u]  = 16'd0;
            m_ptr[u]   = 0;
            m_id[u]    = 0;
            m_valid[u] = 1'b0;
        end else begin
            acc = m_valid[u] && rd;
            pa  = m_pend[u];
            if (acc) pa[m_id[u]] = 1'b0;
            pn = rr ? (acc ? (m_id[u] + 1) % 16 : m_ptr[u]) : 0;
            if (!m_valid[u] || acc) begin
                found = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (!found && pa[(pn + k) % 16]) begin
                        found   = 1'b1;
                        m_id[u] = (pn + k) % 16;
                    end
                end
                m_valid[u] = found;
            end
            m_pend[u] = pa | l;
            m_ptr[u]  = pn;
        end
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pend[u][i]);
        if (u == 0) exp_q0.push_back({m_valid[u], 4'(m_id[u]), m_pend[u], 5'(n)});
        else        exp_q1.push_back({m_valid[u], 4'(m_id[u]), m_pend[u], 5'(n)});
    endtask

    task automatic cyc(input logic rst_l, input logic [15:0] l, input logic rd);
        rst_n = rst_l;
        line  = l;
        ready = rd;
        @(posedge clk);
        model_step(0, 1'b1, rst_l, l, rd);
        model_step(1, 1'b0, rst_l, l, rd);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 16'hFFFF, 1'b1);
        cyc(1'b0, 16'hFFFF, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            chk("rr_valid",   32'(valid0),   32'(e[25]));
            chk("rr_id",      32'(id0),      32'(e[24:21]));
            chk("rr_pending", 32'(pending0), 32'(e[20:5]));
            chk("rr_count",   32'(count0),   32'(e[4:0]));
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            chk("fp_valid",   32'(valid1),   32'(e[25]));
            chk("fp_id",      32'(id1),      32'(e[24:21]));
            chk("fp_pending", 32'(pending1), 32'(e[20:5]));
            chk("fp_count",   32'(count1),   32'(e[4:0]));
        end
    end

    initial begin
        logic [15:0] l;
        rst_n = 1'b0;
        line  = 16'd0;
        ready = 1'b0;

        // Reset with requests present: everything is dropped.
        cyc(1'b0, 16'hFFFF, 1'b1);
        cyc(1'b0, 16'hFFFF, 1'b1);
        chk("reset_valid",   32'(valid0),   32'd0);
        chk("reset_id",      32'(id0),      32'd0);
        chk("reset_pending", 32'(pending0), 32'd0);
        chk("reset_count",   32'(count0),   32'd0);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("post_reset_valid",   32'(valid0),   32'd0);
        chk("post_reset_pending", 32'(pending0), 32'd0);

        // Single request: offer two edges later, gone after accept.
        cyc(1'b1, 16'h0020, 1'b1);
        chk("single_n1_valid", 32'(valid0), 32'd0);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("single_valid", 32'(valid0), 32'd1);
        chk("single_id",    32'(id0),    32'd5);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("single_drop_valid",   32'(valid0),   32'd0);
        chk("single_drop_pending", 32'(pending0), 32'd0);

        // Round-robin order 0, 8, 15 back to back.
        do_reset();
        cyc(1'b1, 16'h8101, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("rr_order_0", 32'(id0), 32'd0);
        chk("rr_order_count", 32'(count0), 32'd3);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("rr_order_8", 32'(id0), 32'd8);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("rr_order_15", 32'(id0), 32'd15);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("rr_order_end_valid", 32'(valid0), 32'd0);

        // Wrap search from ptr=9 over pending 0x0041.
        do_reset();
        cyc(1'b1, 16'h0100, 1'b1);
        cyc(1'b1, 16'h0000, 1'b0);
        chk("wrap_offer8", 32'(id0), 32'd8);
        cyc(1'b1, 16'h0041, 1'b1);
        chk("wrap_gap_valid", 32'(valid0),   32'd0);
        chk("wrap_pending",   32'(pending0), 32'h0041);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("wrap_id0", 32'(id0), 32'd0);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("wrap_id6", 32'(id0), 32'd6);

        // Fixed priority returns to the low index; round robin keeps going up.
        do_reset();
        cyc(1'b1, 16'h00C1, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("prio_first_rr", 32'(id0), 32'd0);
        chk("prio_first_fp", 32'(id1), 32'd0);
        cyc(1'b1, 16'h0001, 1'b1);
        chk("prio_second_rr", 32'(id0), 32'd6);
        chk("prio_second_fp", 32'(id1), 32'd6);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("prio_third_rr", 32'(id0), 32'd7);
        chk("prio_third_fp", 32'(id1), 32'd0);

        // Backpressure: offer stays put while new lines arrive.
        do_reset();
        cyc(1'b1, 16'h0004, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h0001, 1'b0);
            chk("bp_hold_valid", 32'(valid0), 32'd1);
            chk("bp_hold_id",    32'(id0),    32'd2);
        end
        cyc(1'b1, 16'h0000, 1'b1);
        chk("bp_next_id", 32'(id0), 32'd0);
        chk("bp_next_valid", 32'(valid0), 32'd1);

        // Set/clear collision re-arms the accepted line.
        do_reset();
        cyc(1'b1, 16'h0049, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("coll_offer3", 32'(id0), 32'd3);
        cyc(1'b1, 16'h0008, 1'b1);
        chk("coll_pending", 32'(pending0), 32'h0048);
        chk("coll_count",   32'(count0),   32'd2);
        chk("coll_id6",     32'(id0),      32'd6);
        cyc(1'b1, 16'h0000, 1'b1);
        chk("coll_reoffer3", 32'(id0), 32'd3);

        // All lines at once drains as 16 consecutive ids.
        do_reset();
        cyc(1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 16'h0000, 1'b1);
            chk("burst_id",    32'(id0),    32'(i));
            chk("burst_count", 32'(count0), 32'(16 - i));
        end
        cyc(1'b1, 16'h0000, 1'b1);
        chk("burst_end_valid", 32'(valid0), 32'd0);

        // Random traffic with occasional reset, mid-offer included.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    l = 16'($urandom);
                2, 3:    l = 16'($urandom) & 16'($urandom) & 16'($urandom);
                4:       l = 16'h0001 << $urandom_range(0, 15);
                default: l = 16'h0000;
            endcase
            cyc(($urandom_range(0, 299) != 0), l, ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
